mux4_1_serializer: RTL and testbench
====================================

Name: mux4_1_serializer

Overview:
- Transmit-side counterpart of the 1:4 byte demultiplexer. Accepts one 4-lane word (four bytes plus per-lane valids) and emits it as one byte per clk4f cycle in lane order 0,1,2,3.
- A single-word holding buffer decouples lane loading from serialization, giving sustained back-to-back throughput of one word every 4 cycles.
- Sits between the parallel lane logic and the serial byte stream that feeds the lane-striping receiver.

Parameters:
- DATA_W, 8, width of each lane and of the serial output byte.

Ports:
- clk4f  input  1  single clock; output byte rate.
- reset  input  1  asynchronous, active-low reset.
- in0  input  DATA_W  lane 0 byte (emitted first).
- in1  input  DATA_W  lane 1 byte.
- in2  input  DATA_W  lane 2 byte.
- in3  input  DATA_W  lane 3 byte (emitted last).
- valid_in0..valid_in3  input  1 each  per-lane valid qualifiers.
- load  input  1  word strobe; accepted when load && in_ready at a rising edge.
- in_ready  output  1  holding buffer empty; a word may be loaded.
- out0  output  DATA_W  serial byte.
- valid_out0  output  1  out0 carries a valid byte this cycle.
- overflow  output  1  sticky: load asserted while in_ready=0.

Interface (already decided):
- One clock; reset is asynchronous and active-low. Ports are named clk4f and reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - out0=0, valid_out0=0, in_ready=1, overflow=0.
  - Holding buffer empty, shift register empty, phase=0.
  - Reset mid-word discards the partial word. No residual bytes appear after release.
- State: 2-bit phase counter, busy flag, holding buffer (4 bytes + 4 valids + full flag), shift register (lanes 1..3 + valids).
- Accept:
  - At an edge with load=1 and in_ready=1, the lanes and valids are captured into the holding buffer and full is set.
  - in_ready = ~full, driven from a register (no combinational path from load).
- Launch (busy=0 or phase=3, and full=1):
  - At the edge, the output register takes lane0 and the shift register takes lanes 1..3.
  - full clears, busy=1, phase=1.
  - Launch and a new accept never coincide, because in_ready was 0.
- Shift (busy=1, phase=1 or 2):
  - Output register takes lane[phase]; phase increments.
- Last byte (busy=1, phase=3):
  - Output register takes lane3.
  - If full=1, the next edge launches the next word (no bubble). Otherwise busy clears and phase returns to 0.
- Per-byte output:
  - valid_out0 = that lane's valid.
  - If the lane valid=0, out0=0 (data is masked, never leaked).
  - Lane invalidity does not skip the slot: all 4 slots are always emitted.
- Idle (busy=0, full=0): out0=0, valid_out0=0.
- Latency:
  - Word accepted at edge N while idle: lane0 appears after edge N+1, lane3 after edge N+4.
  - in_ready returns to 1 after edge N+1.
- Throughput: 1 word / 4 cycles sustained. Next load is accepted any time after the launch edge.
- Overflow:
  - load=1 while in_ready=0 drops the word; buffer contents are unchanged.
  - overflow sets on that edge and stays 1 until reset.
- out0 and valid_out0 are registered outputs. No combinational path from inputs to outputs.

Test Plan:
- Reset, then idle 10 cycles -> out0=0x00, valid_out0=0, in_ready=1, overflow=0 throughout.
- Single word {in0..in3}={0xA0,0xB1,0xC2,0xD3}, all valid, load pulsed at edge N -> out0 = A0,B1,C2,D3 after edges N+1..N+4 with valid_out0=1; then valid_out0=0, out0=0x00.
- Two words back-to-back (second word {0x10,0x11,0x12,0x13} loaded at first edge in_ready=1 after the first) -> 8 contiguous valid bytes A0,B1,C2,D3,10,11,12,13 with no bubble.
- Word {0x55,0x66,0x77,0x88} with valid_in2=0 -> bytes 55,66,00,88; valid_out0 pattern 1,1,0,1.
- Load held high for 6 cycles with the same word -> overflow=1 from the first refused edge and remains 1; output stream contains only whole, non-duplicated-by-overflow words (one per accepted load).
- Reset asserted asynchronously mid-clock after the second byte of a word -> outputs and in_ready return to reset values immediately; after release, no remaining bytes are emitted.

Source files
------------

// File: rtl/mux4_1_serializer.sv
// 4:1 byte serializer: a one-word holding buffer feeds a shift register that
// emits lanes 0..3 on consecutive clk4f cycles; invalid lanes are emitted as 0.
module mux4_1_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic              load,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0,
    output logic              valid_out0,
    output logic              overflow
);

    // phase | meaning (while busy)
    // 1     | lane0 on output, lane1 next
    // 2     | lane1 on output, lane2 next
    // 3     | lane2 on output, lane3 next; busy clears on that edge
    // 0     | idle (busy=0)
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_L1   = 2'd1;
    localparam logic [1:0] PH_L2   = 2'd2;

    logic [3:0][DATA_W-1:0] hold_data_q, hold_data_d;
    logic [3:0]             hold_vld_q, hold_vld_d;
    logic                   full_q, full_d;
    logic [2:0][DATA_W-1:0] shift_data_q, shift_data_d;
    logic [2:0]             shift_vld_q, shift_vld_d;
    logic                   busy_q, busy_d;
    logic [1:0]             phase_q, phase_d;
    logic [DATA_W-1:0]      out_q, out_d;
    logic                   vout_q, vout_d;
    logic                   ovf_q, ovf_d;
    logic                   accept, launch;

    function automatic logic [DATA_W-1:0] mask_lane(input logic [DATA_W-1:0] d,
                                                    input logic v);
        return v ? d : '0;
    endfunction

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_vld_d   = hold_vld_q;
        full_d       = full_q;
        shift_data_d = shift_data_q;
        shift_vld_d  = shift_vld_q;
        busy_d       = busy_q;
        phase_d      = phase_q;
        out_d        = '0;
        vout_d       = 1'b0;
        ovf_d        = ovf_q;

        accept = load & ~full_q;
        // Busy always drops on the lane3 edge, so a waiting word launches on
        // the very next edge with no bubble.
        launch = full_q & ~busy_q;

        if (load & full_q) begin
            ovf_d = 1'b1;
        end

        if (launch) begin
            out_d        = mask_lane(hold_data_q[0], hold_vld_q[0]);
            vout_d       = hold_vld_q[0];
            shift_data_d = hold_data_q[3:1];
            shift_vld_d  = hold_vld_q[3:1];
            full_d       = 1'b0;
            busy_d       = 1'b1;
            phase_d      = PH_L1;
        end else if (busy_q) begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
                PH_L1: begin
                    out_d  = mask_lane(shift_data_q[0], shift_vld_q[0]);
                    vout_d = shift_vld_q[0];
                end
                PH_L2: begin
                    out_d  = mask_lane(shift_data_q[1], shift_vld_q[1]);
                    vout_d = shift_vld_q[1];
                end
                default: begin
                    out_d   = mask_lane(shift_data_q[2], shift_vld_q[2]);
                    vout_d  = shift_vld_q[2];
                    busy_d  = 1'b0;
                    phase_d = PH_IDLE;
                end
            endcase
        end

        if (accept) begin
            hold_data_d = {in3, in2, in1, in0};
            hold_vld_d  = {valid_in3, valid_in2, valid_in1, valid_in0};
            full_d      = 1'b1;
        end
    end

    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            hold_data_q  <= '0;
            hold_vld_q   <= '0;
            full_q       <= 1'b0;
            shift_data_q <= '0;
            shift_vld_q  <= '0;
            busy_q       <= 1'b0;
            phase_q      <= PH_IDLE;
            out_q        <= '0;
            vout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_vld_q   <= hold_vld_d;
            full_q       <= full_d;
            shift_data_q <= shift_data_d;
            shift_vld_q  <= shift_vld_d;
            busy_q       <= busy_d;
            phase_q      <= phase_d;
            out_q        <= out_d;
            vout_q       <= vout_d;
            ovf_q        <= ovf_d;
        end
    end

    assign in_ready   = ~full_q;
    assign out0       = out_q;
    assign valid_out0 = vout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mux4_1_serializer.sv
// Bench for mux4_1_serializer: table vectors, directed corner sequences and
// random traffic checked against a word-scheduling reference model.
module tb_mux4_1_serializer;

    logic       clk4f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
    logic       load = 1'b0;
    logic       in_ready;
    logic [7:0] out0;
    logic       valid_out0;
    logic       overflow;

    mux4_1_serializer #(.DATA_W(8)) dut (
        .clk4f(clk4f), .reset(reset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .valid_in0(valid_in0), .valid_in1(valid_in1),
        .valid_in2(valid_in2), .valid_in3(valid_in3),
        .load(load), .in_ready(in_ready),
        .out0(out0), .valid_out0(valid_out0), .overflow(overflow)
    );

    always #5 clk4f = ~clk4f;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each accepted word is scheduled to launch at
    // max(accept_edge + 1, previous_launch + 4); its four bytes occupy the
    // four edges from the launch on. The buffer is busy until the launch.
    logic [7:0] exp_b [int];
    logic       exp_v [int];
    int         edge_cnt;
    int         next_free;
    int         last_launch;
    bit         m_ovf;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  vld;
        logic [31:0] exp_data;
        logic [3:0]  exp_vld;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_b.delete();
        exp_v.delete();
        edge_cnt    = 0;
        next_free   = 0;
        last_launch = 0;
        m_ovf       = 1'b0;
    endtask

    task automatic tick(input bit ld, input logic [31:0] data, input logic [3:0] vld);
        int l;
        bit ready;
        load = ld;
        {in3, in2, in1, in0} = data;
        {valid_in3, valid_in2, valid_in1, valid_in0} = vld;
        ready = (edge_cnt >= last_launch);
        if (ld && ready) begin
            l = (edge_cnt + 2 > next_free) ? edge_cnt + 2 : next_free;
            for (int k = 0; k < 4; k++) begin
                exp_v[l + k] = vld[k];
                exp_b[l + k] = vld[k] ? data[8*k +: 8] : 8'h00;
            end
            next_free   = l + 4;
            last_launch = l;
        end else if (ld) begin
            m_ovf = 1'b1;
        end
        @(posedge clk4f);
        edge_cnt++;
        @(negedge clk4f);
        load = 1'b0;
        check("out0",       {24'h0, out0},       {24'h0, exp_b.exists(edge_cnt) ? exp_b[edge_cnt] : 8'h00});
        check("valid_out0", {31'h0, valid_out0}, {31'h0, exp_v.exists(edge_cnt) ? exp_v[edge_cnt] : 1'b0});
        check("in_ready",   {31'h0, in_ready},   {31'h0, edge_cnt >= last_launch});
        check("overflow",   {31'h0, overflow},   {31'h0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 4'h0);
    endtask

    vec_t       vecs [5];
    logic [7:0] seq  [8];

    initial begin
        vecs[0] = '{32'hD3C2B1A0, 4'b1111, 32'hD3C2B1A0, 4'b1111};
        vecs[1] = '{32'h88776655, 4'b1011, 32'h88006655, 4'b1011};
        vecs[2] = '{32'hFFFFFFFF, 4'b0000, 32'h00000000, 4'b0000};
        vecs[3] = '{32'h04030201, 4'b0001, 32'h00000001, 4'b0001};
        vecs[4] = '{32'h00000000, 4'b1111, 32'h00000000, 4'b1111};
        seq = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h10, 8'h11, 8'h12, 8'h13};

        // reset values
        model_reset();
        repeat (2) @(negedge clk4f);
        check("rst_out0",     {24'h0, out0},       32'h0);
        check("rst_valid",    {31'h0, valid_out0}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready},   32'h1);
        check("rst_overflow", {31'h0, overflow},   32'h0);
        reset = 1'b1;
        idle(10);

        // table vectors, each from idle
        foreach (vecs[v]) begin
            tick(1'b1, vecs[v].data, vecs[v].vld);
            for (int k = 0; k < 4; k++) begin
                tick(1'b0, 32'h0, 4'h0);
                check("tbl_byte",  {24'h0, out0},       {24'h0, vecs[v].exp_data[8*k +: 8]});
                check("tbl_valid", {31'h0, valid_out0}, {31'h0, vecs[v].exp_vld[k]});
            end
            tick(1'b0, 32'h0, 4'h0);
            check("tbl_idle_valid", {31'h0, valid_out0}, 32'h0);
            check("tbl_idle_out",   {24'h0, out0},       32'h0);
        end

        // back-to-back words: no bubble between them
        tick(1'b1, 32'hD3C2B1A0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) tick(1'b1, 32'h13121110, 4'hF);
            else        tick(1'b0, 32'h0, 4'h0);
            check("b2b_byte",  {24'h0, out0},       {24'h0, seq[i]});
            check("b2b_valid", {31'h0, valid_out0}, 32'h1);
        end
        tick(1'b0, 32'h0, 4'h0);
        check("b2b_end_valid", {31'h0, valid_out0}, 32'h0);

        // load held for six cycles
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 32'h44332211, 4'hF);
            if (i >= 1) check("ovf_sticky", {31'h0, overflow}, 32'h1);
        end
        idle(12);
        check("ovf_hold", {31'h0, overflow}, 32'h1);

        // asynchronous reset after the second byte
        tick(1'b1, 32'hDDCCBBAA, 4'hF);
        tick(1'b0, 32'h0, 4'h0);
        tick(1'b0, 32'h0, 4'h0);
        check("pre_rst_byte", {24'h0, out0}, 32'hBB);
        #2 reset = 1'b0;
        #1;
        check("arst_out0",     {24'h0, out0},       32'h0);
        check("arst_valid",    {31'h0, valid_out0}, 32'h0);
        check("arst_in_ready", {31'h0, in_ready},   32'h1);
        check("arst_overflow", {31'h0, overflow},   32'h0);
        @(negedge clk4f);
        reset = 1'b1;
        model_reset();
        idle(8);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) != 0), $urandom, 4'($urandom));
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
